// File: rtl/ipv4_rx.sv
// ipv4_rx: IPv4 receive stage that parses and validates the header, skips options and forwards the trimmed payload.
// Define IPV4_RX_CSUM_EN to build the header checksum check (drop code 5).

module ipv4_rx #(
   parameter int         DATA_W = 16,
   parameter logic [7:0] PROTO  = 8'd17,
   localparam int        LEN_W  = $clog2(DATA_W/8+1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cancel_i,
   input  logic              valid_i,
   input  logic              start_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [LEN_W-1:0]  len_i,
   input  logic              crc_err_i,
   input  logic [31:0]       local_ip_i,
   output logic              valid_o,
   output logic              start_o,
   output logic              last_o,
   output logic [DATA_W-1:0] data_o,
   output logic [LEN_W-1:0]  len_o,
   output logic [31:0]       src_ip_o,
   output logic              drop_o,
   output logic [2:0]        drop_code_o
);

   generate
      if (DATA_W != 16) begin : g_width_check
         $error("ipv4_rx supports DATA_W=16 only");
      end
   endgenerate

   typedef enum logic [2:0] {IDLE, HEAD, OPT, DATA, SKIP} state_t;

   state_t      state, state_next;
   logic [4:0]  wcnt, wcnt_next;
   logic [15:0] word;
   logic [3:0]  version, ihl;
   logic [15:0] total_len, frag, src_hi, src_lo, dst_hi, dst_lo, rem, hdr_bytes;
   logic [7:0]  proto;
   logic [31:0] dst_full;
   logic [4:0]  last_word;
   logic        first_pending, payload_seen;
   logic        ver_bad_now, csum_bad;
   logic [2:0]  eval_code, code;
   logic        begin_hdr, hdr_cap, opt_cap, eval_now, fwd, fwd_last, drop, clr_seen;
   logic        unused_ok;

   assign word        = {data_i[7:0], data_i[15:8]};
   assign hdr_bytes   = {10'd0, ihl, 2'b00};
   assign last_word   = {ihl, 1'b0} - 5'd1;
   assign dst_full    = (state == HEAD) ? {dst_hi, word} : {dst_hi, dst_lo};
   assign ver_bad_now = (data_i[7:4] != 4'd4) || (data_i[3:0] < 4'd5);
   assign unused_ok   = ^{len_i, frag[15:14]};

`ifdef IPV4_RX_CSUM_EN
   logic [15:0] csum, csum_next;
   logic [16:0] csum_sum;

   assign csum_sum  = {1'b0, csum} + {1'b0, word};
   assign csum_next = csum_sum[15:0] + {15'd0, csum_sum[16]};
   assign csum_bad  = (csum_next != 16'hFFFF);

   always_ff @(posedge clk) begin
      if (reset) begin
         csum <= '0;
      end else if (begin_hdr) begin
         csum <= word;
      end else if (hdr_cap || opt_cap) begin
         csum <= csum_next;
      end
   end
`else
   assign csum_bad = 1'b0;
`endif

   // Header checks in priority order; dst low word comes straight off the bus when word 9 ends the header.
   always_comb begin
      eval_code = 3'd0;
      if (version != 4'd4 || ihl < 4'd5)                       eval_code = 3'd1;
      else if (frag[13] || frag[12:0] != 13'd0)                eval_code = 3'd2;
      else if (proto != PROTO)                                 eval_code = 3'd3;
      else if (dst_full != local_ip_i && dst_full != 32'hFFFFFFFF) eval_code = 3'd4;
      else if (csum_bad)                                       eval_code = 3'd5;
      else if (total_len < hdr_bytes + 16'd1)                  eval_code = 3'd6;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         wcnt  <= '0;
      end else begin
         state <= state_next;
         wcnt  <= wcnt_next;
      end
   end

   always_comb begin
      state_next = state;
      wcnt_next  = wcnt;
      begin_hdr  = 1'b0;
      hdr_cap    = 1'b0;
      opt_cap    = 1'b0;
      eval_now   = 1'b0;
      fwd        = 1'b0;
      fwd_last   = 1'b0;
      drop       = 1'b0;
      code       = 3'd0;
      clr_seen   = 1'b0;
      if (cancel_i) begin
         state_next = IDLE;
         wcnt_next  = '0;
         clr_seen   = 1'b1;
         if (state == DATA) begin
            drop = 1'b1;
            code = 3'd6;
         end
      end else begin
         if (valid_i) begin
            if (start_i) begin
               begin_hdr = 1'b1;
               wcnt_next = 5'd1;
               if (state == IDLE || state == SKIP) begin
                  if (ver_bad_now) begin
                     state_next = SKIP;
                     drop       = 1'b1;
                     code       = 3'd1;
                  end else begin
                     state_next = HEAD;
                  end
               end else begin
                  // A new frame arrived before this one finished: short frame.
                  state_next = HEAD;
                  drop       = 1'b1;
                  code       = 3'd6;
               end
            end else begin
               case (state)
                  HEAD: begin
                     hdr_cap   = 1'b1;
                     wcnt_next = wcnt + 5'd1;
                     if (wcnt == 5'd9) begin
                        if (ihl > 4'd5) state_next = OPT;
                        else            eval_now   = 1'b1;
                     end
                  end
                  OPT: begin
                     opt_cap   = 1'b1;
                     wcnt_next = wcnt + 5'd1;
                     if (wcnt == last_word) eval_now = 1'b1;
                  end
                  DATA: begin
                     fwd = 1'b1;
                     if (rem <= 16'd2) begin
                        fwd_last   = 1'b1;
                        state_next = SKIP;
                     end
                  end
                  default: ;
               endcase
               if (eval_now) begin
                  if (eval_code != 3'd0) begin
                     state_next = SKIP;
                     drop       = 1'b1;
                     code       = eval_code;
                  end else begin
                     state_next = DATA;
                  end
               end
            end
         end
         if (crc_err_i && payload_seen && !drop) begin
            drop     = 1'b1;
            code     = 3'd7;
            clr_seen = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_o       <= 1'b0;
         start_o       <= 1'b0;
         last_o        <= 1'b0;
         data_o        <= '0;
         len_o         <= '0;
         src_ip_o      <= '0;
         drop_o        <= 1'b0;
         drop_code_o   <= 3'd0;
         version       <= '0;
         ihl           <= '0;
         total_len     <= '0;
         frag          <= '0;
         proto         <= '0;
         src_hi        <= '0;
         src_lo        <= '0;
         dst_hi        <= '0;
         dst_lo        <= '0;
         rem           <= '0;
         first_pending <= 1'b0;
         payload_seen  <= 1'b0;
      end else begin
         valid_o     <= fwd;
         start_o     <= fwd & first_pending;
         last_o      <= fwd_last;
         drop_o      <= drop;
         drop_code_o <= code;
         if (begin_hdr) begin
            version       <= data_i[7:4];
            ihl           <= data_i[3:0];
            first_pending <= 1'b0;
            payload_seen  <= 1'b0;
         end
         if (hdr_cap) begin
            case (wcnt)
               5'd1:    total_len <= word;
               5'd3:    frag      <= word;
               5'd4:    proto     <= word[7:0];
               5'd6:    src_hi    <= word;
               5'd7:    src_lo    <= word;
               5'd8:    dst_hi    <= word;
               5'd9:    dst_lo    <= word;
               default: ;
            endcase
         end
         if (eval_now && eval_code == 3'd0) begin
            rem           <= total_len - hdr_bytes;
            first_pending <= 1'b1;
         end
         // src_ip_o only moves together with start_o so it stays put for the whole packet.
         if (fwd) begin
            data_o        <= data_i;
            len_o         <= fwd_last ? rem[LEN_W-1:0] : LEN_W'(2);
            rem           <= rem - 16'd2;
            first_pending <= 1'b0;
            payload_seen  <= 1'b1;
            if (first_pending) src_ip_o <= {src_hi, src_lo};
         end
         if (clr_seen) payload_seen <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ipv4_rx.sv
// Testbench for ipv4_rx: per-beat vector table built from directed packets plus reset corner sequences.

module tb_ipv4_rx;

   localparam logic [31:0] LOCAL_IP = 32'hC0A8_0102;
   localparam logic [31:0] SRC_A    = 32'h0A00_0001;
   localparam logic [31:0] SRC_B    = 32'h0A00_0002;
`ifdef IPV4_RX_CSUM_EN
   localparam logic [2:0]  CSUM_CODE = 3'd5;
`else
   localparam logic [2:0]  CSUM_CODE = 3'd0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        cancel_i, valid_i, start_i, crc_err_i;
   logic [15:0] data_i;
   logic [1:0]  len_i;
   logic [31:0] local_ip_i;
   logic        valid_o, start_o, last_o, drop_o;
   logic [15:0] data_o;
   logic [1:0]  len_o;
   logic [31:0] src_ip_o;
   logic [2:0]  drop_code_o;

   always #5 clk = ~clk;

   ipv4_rx dut (
      .clk(clk), .reset(reset), .cancel_i(cancel_i), .valid_i(valid_i), .start_i(start_i),
      .data_i(data_i), .len_i(len_i), .crc_err_i(crc_err_i), .local_ip_i(local_ip_i),
      .valid_o(valid_o), .start_o(start_o), .last_o(last_o), .data_o(data_o), .len_o(len_o),
      .src_ip_o(src_ip_o), .drop_o(drop_o), .drop_code_o(drop_code_o)
   );

   // One record per input beat; expectations describe the outputs right after that beat's clock edge.
   typedef struct {
      string       name;
      logic        cancel, valid, start, crc_err;
      logic [15:0] data;
      logic [1:0]  len;
      logic        e_valid, e_start, e_last, e_drop;
      logic [15:0] e_data;
      logic [1:0]  e_len;
      logic [2:0]  e_code;
      logic        chk_src;
      logic [31:0] e_src;
   } vec_t;

   vec_t vecs[$];
   int   applied = 0;
   int   miscompares = 0;

   function automatic vec_t mk(input string name, input logic valid, input logic start, input logic [15:0] data);
      vec_t v;
      v.name = name; v.cancel = 1'b0; v.valid = valid; v.start = start; v.crc_err = 1'b0;
      v.data = data; v.len = 2'd2;
      v.e_valid = 1'b0; v.e_start = 1'b0; v.e_last = 1'b0; v.e_drop = 1'b0;
      v.e_data = 16'h0; v.e_len = 2'd0; v.e_code = 3'd0; v.chk_src = 1'b0; v.e_src = 32'h0;
      return v;
   endfunction

   // Builds a whole MAC payload (header with a correctly computed checksum, payload, padding) and its expectations.
   function automatic void add_packet(input string name, input logic [3:0] ver, input logic [3:0] ihl,
                                      input logic [15:0] tl, input logic [15:0] frag, input logic [7:0] proto,
                                      input logic [31:0] src, input logic [31:0] dst, input int pad_words,
                                      input bit corrupt, input logic [2:0] start_code, input logic [2:0] hdr_code,
                                      input int max_beats);
      logic [15:0] w[$];
      logic [31:0] s;
      int hdr_words, rem, nbeats, total, p;
      bit fwd;
      vec_t v;
      w.push_back({ver, ihl, 8'h00});
      w.push_back(tl);
      w.push_back(16'h1234);
      w.push_back(frag);
      w.push_back({8'h40, proto});
      w.push_back(16'h0000);
      w.push_back(src[31:16]);
      w.push_back(src[15:0]);
      w.push_back(dst[31:16]);
      w.push_back(dst[15:0]);
      for (int k = 0; k < (int'(ihl) - 5) * 2; k++) w.push_back(16'h0101);
      s = 32'h0;
      foreach (w[i]) s = s + {16'h0, w[i]};
      while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
      w[5] = ~s[15:0];
      if (corrupt) w[5] = w[5] ^ 16'hFF00;
      hdr_words = w.size();
      fwd    = (hdr_code == 3'd0) && (start_code != 3'd1);
      rem    = int'(tl) - int'(ihl) * 4;
      nbeats = fwd ? (rem + 1) / 2 : 0;
      total  = (pad_words > hdr_words + nbeats) ? pad_words : hdr_words + nbeats;
      for (int b = 0; b < total && b < max_beats; b++) begin
         v = mk($sformatf("%s[%0d]", name, b), 1'b1, b == 0,
                (b < hdr_words) ? {w[b][7:0], w[b][15:8]} : 16'hA500 + 16'(b));
         if (b == 0 && start_code != 3'd0) begin
            v.e_drop = 1'b1; v.e_code = start_code;
         end
         if (b == hdr_words - 1 && hdr_code != 3'd0) begin
            v.e_drop = 1'b1; v.e_code = hdr_code;
         end
         p = b - hdr_words;
         if (fwd && p >= 0 && p < nbeats) begin
            v.e_valid = 1'b1;
            v.e_start = (p == 0);
            v.e_last  = (p == nbeats - 1);
            v.e_data  = v.data;
            v.e_len   = (v.e_last && (rem % 2 == 1)) ? 2'd1 : 2'd2;
            if (v.e_last && (rem % 2 == 1)) v.len = 2'd1;
            if (p == 0) begin
               v.chk_src = 1'b1; v.e_src = src;
            end
         end
         vecs.push_back(v);
      end
   endfunction

   task automatic applyStimulus(input vec_t v);
      cancel_i  = v.cancel;
      valid_i   = v.valid;
      start_i   = v.start;
      crc_err_i = v.crc_err;
      data_i    = v.data;
      len_i     = v.len;
   endtask

   task automatic checkOutput(input vec_t v);
      bit ok = 1'b1;
      applied++;
      if (valid_o !== v.e_valid || start_o !== v.e_start || last_o !== v.e_last || drop_o !== v.e_drop) ok = 1'b0;
      if (v.e_drop && drop_code_o !== v.e_code) ok = 1'b0;
      if (v.e_valid && (data_o !== v.e_data || len_o !== v.e_len)) ok = 1'b0;
      if (v.chk_src && src_ip_o !== v.e_src) ok = 1'b0;
      if (!ok) begin
         miscompares++;
         $display("[TB] FAIL %s: got valid=%b start=%b last=%b data=%h len=%0d drop=%b code=%0d src=%h; expected valid=%b start=%b last=%b data=%h len=%0d drop=%b code=%0d src=%h",
                  v.name, valid_o, start_o, last_o, data_o, len_o, drop_o, drop_code_o, src_ip_o,
                  v.e_valid, v.e_start, v.e_last, v.e_data, v.e_len, v.e_drop, v.e_code, v.e_src);
      end
   endtask

   task automatic checkReset(input string name);
      applied++;
      if (valid_o !== 1'b0 || start_o !== 1'b0 || last_o !== 1'b0 || drop_o !== 1'b0 || len_o !== 2'd0 ||
          drop_code_o !== 3'd0 || data_o !== 16'h0 || src_ip_o !== 32'h0) begin
         miscompares++;
         $display("[TB] FAIL %s: got valid=%b start=%b last=%b drop=%b len=%0d code=%0d data=%h src=%h; expected all zero",
                  name, valid_o, start_o, last_o, drop_o, len_o, drop_code_o, data_o, src_ip_o);
      end
   endtask

   task automatic run_vecs();
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         @(posedge clk);
         #1;
         checkOutput(vecs[i]);
      end
      vecs.delete();
   endtask

   initial begin
      vec_t v;
      reset = 1'b1; cancel_i = 1'b0; valid_i = 1'b0; start_i = 1'b0; crc_err_i = 1'b0;
      data_i = 16'h0; len_i = 2'd0; local_ip_i = LOCAL_IP;
      repeat (2) @(posedge clk);
      #1;
      checkReset("reset_init");
      reset = 1'b0;

      // Clean packet followed by an FCS error, then an FCS error that should be ignored.
      add_packet("clean", 4'd4, 4'd5, 16'd28, 16'h0000, 8'd17, SRC_A, LOCAL_IP, 23, 1'b0, 3'd0, 3'd0, 999);
      v = mk("crc_after_payload", 1'b0, 1'b0, 16'h0); v.crc_err = 1'b1; v.e_drop = 1'b1; v.e_code = 3'd7;
      vecs.push_back(v);
      v = mk("crc_repeat", 1'b0, 1'b0, 16'h0); v.crc_err = 1'b1;
      vecs.push_back(v);
      add_packet("options", 4'd4, 4'd6, 16'd33, 16'h0000, 8'd17, SRC_B, LOCAL_IP, 23, 1'b0, 3'd0, 3'd0, 999);
      add_packet("tcp", 4'd4, 4'd5, 16'd28, 16'h0000, 8'd6, SRC_A, LOCAL_IP, 23, 1'b0, 3'd0, 3'd3, 999);
      v = mk("crc_no_payload", 1'b0, 1'b0, 16'h0); v.crc_err = 1'b1;
      vecs.push_back(v);
      add_packet("bad_csum", 4'd4, 4'd5, 16'd28, 16'h0000, 8'd17, SRC_A, LOCAL_IP, 23, 1'b1, 3'd0, CSUM_CODE, 999);
      add_packet("mf_set", 4'd4, 4'd5, 16'd28, 16'h2000, 8'd17, SRC_A, LOCAL_IP, 23, 1'b0, 3'd0, 3'd2, 999);
      add_packet("frag_off", 4'd4, 4'd5, 16'd28, 16'h0001, 8'd17, SRC_A, LOCAL_IP, 23, 1'b0, 3'd0, 3'd2, 999);
      add_packet("df_ok", 4'd4, 4'd5, 16'd30, 16'h4000, 8'd17, SRC_B, LOCAL_IP, 23, 1'b0, 3'd0, 3'd0, 999);
      add_packet("dst_miss", 4'd4, 4'd5, 16'd28, 16'h0000, 8'd17, SRC_A, 32'hC0A8_0103, 23, 1'b0, 3'd0, 3'd4, 999);
      add_packet("bcast_len21", 4'd4, 4'd5, 16'd21, 16'h0000, 8'd17, SRC_B, 32'hFFFF_FFFF, 23, 1'b0, 3'd0, 3'd0, 999);
      add_packet("len20", 4'd4, 4'd5, 16'd20, 16'h0000, 8'd17, SRC_A, LOCAL_IP, 23, 1'b0, 3'd0, 3'd6, 999);
      add_packet("ver6", 4'd6, 4'd5, 16'd28, 16'h0000, 8'd17, SRC_A, LOCAL_IP, 23, 1'b0, 3'd1, 3'd0, 999);
      add_packet("ihl4", 4'd4, 4'd4, 16'd28, 16'h0000, 8'd17, SRC_A, LOCAL_IP, 23, 1'b0, 3'd1, 3'd0, 999);

      // Cancel on the second payload beat, then a good packet.
      add_packet("cut_data", 4'd4, 4'd5, 16'd28, 16'h0000, 8'd17, SRC_A, LOCAL_IP, 23, 1'b0, 3'd0, 3'd0, 11);
      v = mk("cancel_data", 1'b1, 1'b0, 16'hA50B); v.cancel = 1'b1; v.e_drop = 1'b1; v.e_code = 3'd6;
      vecs.push_back(v);
      add_packet("after_cancel", 4'd4, 4'd5, 16'd28, 16'h0000, 8'd17, SRC_B, LOCAL_IP, 23, 1'b0, 3'd0, 3'd0, 999);

      // Cancel inside the header is silent.
      add_packet("cut_head", 4'd4, 4'd5, 16'd28, 16'h0000, 8'd17, SRC_A, LOCAL_IP, 23, 1'b0, 3'd0, 3'd0, 4);
      v = mk("cancel_head", 1'b1, 1'b0, 16'h5555); v.cancel = 1'b1;
      vecs.push_back(v);
      add_packet("after_cancel_head", 4'd4, 4'd5, 16'd28, 16'h0000, 8'd17, SRC_A, LOCAL_IP, 23, 1'b0, 3'd0, 3'd0, 999);

      // Short frames: a new start_i in DATA and in HEAD restarts parsing with a length drop.
      add_packet("short_data", 4'd4, 4'd5, 16'd28, 16'h0000, 8'd17, SRC_A, LOCAL_IP, 23, 1'b0, 3'd0, 3'd0, 12);
      add_packet("restart_data", 4'd4, 4'd5, 16'd28, 16'h0000, 8'd17, SRC_B, LOCAL_IP, 23, 1'b0, 3'd6, 3'd0, 999);
      add_packet("short_head", 4'd4, 4'd5, 16'd28, 16'h0000, 8'd17, SRC_B, LOCAL_IP, 23, 1'b0, 3'd0, 3'd0, 5);
      add_packet("restart_head", 4'd4, 4'd5, 16'd28, 16'h0000, 8'd17, SRC_A, LOCAL_IP, 23, 1'b0, 3'd6, 3'd0, 999);
      run_vecs();

      // Reset in the middle of DATA, then headerless beats must be ignored.
      add_packet("pre_reset", 4'd4, 4'd5, 16'd28, 16'h0000, 8'd17, SRC_A, LOCAL_IP, 23, 1'b0, 3'd0, 3'd0, 12);
      run_vecs();
      applyStimulus(mk("reset_beat", 1'b1, 1'b0, 16'hA50C));
      reset = 1'b1;
      @(posedge clk);
      #1;
      checkReset("reset_mid_data");
      reset = 1'b0;
      for (int i = 0; i < 5; i++) vecs.push_back(mk($sformatf("post_reset[%0d]", i), 1'b1, 1'b0, 16'hA50D + 16'(i)));
      add_packet("after_reset", 4'd4, 4'd5, 16'd28, 16'h0000, 8'd17, SRC_B, LOCAL_IP, 23, 1'b0, 3'd0, 3'd0, 999);
      run_vecs();

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule
